lsu_mem_sequencer: RTL and testbench

- Multi-cycle sequencer between the decode/control stage and a handshaked data-memory port.
- Accepts one load/store per request (mem_read/mem_write from the control decoder), issues a word-aligned bus access with byte strobes, waits for grant and read data, then returns a sign- or zero-extended result.
- Stalls the pipeline until the access completes and reports misaligned, illegal and timed-out accesses.

---
 rtl/lsu_mem_sequencer_if.sv | 22 ++
 rtl/lsu_mem_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_lsu_mem_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_sequencer_if.sv
// Data-memory port between the load/store sequencer (master) and the memory (slave).
// Requests are word-aligned with byte strobes; read data returns later with rvalid.
interface lsu_mem_sequencer_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/lsu_mem_sequencer.sv
// Multi-cycle load/store sequencer: accepts one op, runs one bus access, returns an
// extended result or an error code, and stalls the pipeline while the access is in flight.
module lsu_mem_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        err,
  output logic [1:0]  err_code,
  lsu_mem_sequencer_if.master dmem
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 32'd1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] daddr_q, daddr_d;
  logic [3:0]  strb_q, strb_d;
  logic [31:0] dwdata_q, dwdata_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  alo_q, alo_d;
  logic        dreq_q, dreq_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [1:0]  code_q, code_d;
  logic        op_s;

  function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] a);
    logic [3:0] s;
    case (size)
      2'd0:    s = 4'b0001 << a;
      2'd1:    s = 4'b0011 << a;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] d;
    case (size)
      2'd0:    d = {4{wd[7:0]}};
      2'd1:    d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] a, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{a, 3'b000} +: 8];
    h = a[1] ? word[31:16] : word[15:0];
    case (size)
      2'd0:    r = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'd1:    r = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  assign op_s = req_valid && (mem_read || mem_write);

  // Next-state, timeout counter and registered-output next values
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    daddr_d  = daddr_q;
    strb_d   = strb_q;
    dwdata_d = dwdata_q;
    size_d   = size_q;
    uns_d    = uns_q;
    alo_d    = alo_q;
    rdata_d  = 32'd0;
    err_d    = 1'b0;
    code_d   = 2'd0;
    case (state_q)
      ST_IDLE: begin
        if (op_s) begin
          if ((mem_read && mem_write) || (mem_size == 2'd3)) begin
            state_d = ST_RESP;
            err_d   = 1'b1;
            code_d  = 2'd2;
          end else if ((mem_size == 2'd1 && addr[0]) ||
                       (mem_size == 2'd2 && addr[1:0] != 2'd0)) begin
            state_d = ST_RESP;
            err_d   = 1'b1;
            code_d  = 2'd1;
          end else begin
            state_d  = ST_REQ;
            cnt_d    = 8'd0;
            we_d     = mem_write;
            daddr_d  = {addr[31:2], 2'b00};
            strb_d   = mem_write ? store_strb(mem_size, addr[1:0]) : 4'b0000;
            dwdata_d = mem_write ? store_data(mem_size, wdata) : 32'd0;
            size_d   = mem_size;
            uns_d    = mem_unsigned;
            alo_d    = addr[1:0];
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (dmem.dmem_gnt) begin
          cnt_d   = 8'd0;
          state_d = we_q ? ST_RESP : ST_WAIT;
        end else if (cnt_q == TMO_LAST) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
          code_d  = 2'd3;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_WAIT: begin
        if (dmem.dmem_rvalid) begin
          state_d = ST_RESP;
          rdata_d = load_extend(dmem.dmem_rdata, size_q, alo_q, uns_q);
        end else if (cnt_q == TMO_LAST) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
          code_d  = 2'd3;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
    dreq_d   = (state_d == ST_REQ);
    rvalid_d = (state_d == ST_RESP);
  end

  // State and output registers; reset abandons any access in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 8'd0;
      we_q     <= 1'b0;
      daddr_q  <= 32'd0;
      strb_q   <= 4'd0;
      dwdata_q <= 32'd0;
      size_q   <= 2'd0;
      uns_q    <= 1'b0;
      alo_q    <= 2'd0;
      dreq_q   <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
      code_q   <= 2'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      daddr_q  <= daddr_d;
      strb_q   <= strb_d;
      dwdata_q <= dwdata_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      alo_q    <= alo_d;
      dreq_q   <= dreq_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      code_q   <= code_d;
    end
  end

  // RESP leaves stall low so the pipeline advances together with the result
  assign req_ready = (state_q == ST_IDLE) && !rst;
  assign stall     = !rst && (((state_q == ST_IDLE) && op_s) ||
                              (state_q == ST_REQ) || (state_q == ST_WAIT));

  assign resp_valid      = rvalid_q;
  assign resp_rdata      = rdata_q;
  assign err             = err_q;
  assign err_code        = code_q;
  assign dmem.dmem_req   = dreq_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = daddr_q;
  assign dmem.dmem_wstrb = strb_q;
  assign dmem.dmem_wdata = dwdata_q;

endmodule

// File: tb/tb_lsu_mem_sequencer.sv
// Scoreboard bench for lsu_mem_sequencer: expected responses are queued when an op is
// driven and compared (data, error, cycle of arrival) when resp_valid pulses.
module tb_lsu_mem_sequencer;
  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        err;
  logic [1:0]  err_code;

  lsu_mem_sequencer_if bus ();

  lsu_mem_sequencer #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .addr(addr), .wdata(wdata), .stall(stall),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .err(err), .err_code(err_code),
    .dmem(bus)
  );

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
    logic [1:0]  code;
  } exp_t;

  exp_t        sb_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          resp_count = 0;
  int          gnt_wait = 0;
  bit          rv_never = 1'b0;
  logic [31:0] mem_word = 32'd0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory responder: grant after gnt_wait request cycles, read data one cycle after grant
  initial begin
    int  req_cnt;
    bit  pend;
    req_cnt = 0;
    pend    = 1'b0;
    bus.dmem_gnt    = 1'b0;
    bus.dmem_rvalid = 1'b0;
    bus.dmem_rdata  = 32'hDEAD_0000;
    forever begin
      @(posedge clk);
      #1;
      bus.dmem_gnt    = 1'b0;
      bus.dmem_rvalid = 1'b0;
      bus.dmem_rdata  = 32'hDEAD_0000;
      if (pend) begin
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = mem_word;
        pend = 1'b0;
      end
      if (bus.dmem_req) begin
        if (req_cnt >= gnt_wait) begin
          bus.dmem_gnt = 1'b1;
          req_cnt = 0;
          if (!bus.dmem_we && !rv_never) pend = 1'b1;
        end else begin
          req_cnt++;
        end
      end else begin
        req_cnt = 0;
      end
    end
  end

  // Response monitor: every resp_valid pulse must match the oldest queued expectation
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (resp_valid) begin
      resp_count++;
      if (sb_q.size() == 0) begin
        check_eq("unexpected_resp", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check_eq("resp_cycle", cyc, e.cyc);
        check_eq("resp_rdata", resp_rdata, e.rdata);
        check_eq("resp_err", {31'd0, err}, {31'd0, e.err});
        check_eq("resp_code", {30'd0, err_code}, {30'd0, e.code});
        check_eq("resp_stall", {31'd0, stall}, 32'd0);
        check_eq("resp_ready", {31'd0, req_ready}, 32'd0);
      end
    end
  end

  task automatic drive_op(input logic rd, input logic wr, input logic [1:0] sz,
                          input logic uns, input logic [31:0] a, input logic [31:0] wd);
    req_valid    = 1'b1;
    mem_read     = rd;
    mem_write    = wr;
    mem_size     = sz;
    mem_unsigned = uns;
    addr         = a;
    wdata        = wd;
  endtask

  task automatic idle_inputs();
    req_valid    = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_size     = 2'd0;
    mem_unsigned = 1'b0;
    addr         = 32'd0;
    wdata        = 32'd0;
  endtask

  // One op from accept to response; called just after a posedge with the DUT idle
  task automatic do_op(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                       input logic uns, input logic [31:0] a, input logic [31:0] wd,
                       input int gw, input bit rvn, input logic [31:0] mword,
                       input logic [31:0] exp_rd, input logic exp_err, input logic [1:0] exp_code,
                       input int lat, input int exp_reqc, input logic [31:0] exp_daddr,
                       input logic [3:0] exp_strb, input logic [31:0] exp_wd);
    int  reqc;
    int  t;
    bit  done;
    exp_t e;
    gnt_wait = gw;
    rv_never = rvn;
    mem_word = mword;
    drive_op(rd, wr, sz, uns, a, wd);
    e.cyc = cyc + lat; e.rdata = exp_rd; e.err = exp_err; e.code = exp_code;
    sb_q.push_back(e);
    @(negedge clk);
    check_eq({tag, "_stall_acc"}, {31'd0, stall}, 32'd1);
    check_eq({tag, "_ready_acc"}, {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    idle_inputs();
    reqc = 0;
    t    = 0;
    done = 1'b0;
    while (!done && t < 40) begin
      @(negedge clk);
      if (bus.dmem_req) begin
        reqc++;
        if (reqc == 1) begin
          check_eq({tag, "_daddr"}, bus.dmem_addr, exp_daddr);
          check_eq({tag, "_wstrb"}, {28'd0, bus.dmem_wstrb}, {28'd0, exp_strb});
          check_eq({tag, "_we"}, {31'd0, bus.dmem_we}, {31'd0, wr});
          if (wr) check_eq({tag, "_wdata"}, bus.dmem_wdata, exp_wd);
        end
      end
      if (resp_valid) done = 1'b1;
      else check_eq({tag, "_stall_busy"}, {31'd0, stall}, 32'd1);
      t++;
    end
    if (!done) check_eq({tag, "_no_resp"}, 32'd0, 32'd1);
    check_eq({tag, "_req_cycles"}, reqc, exp_reqc);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    int k;
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int k;
    rst = 1'b1;
    idle_inputs();
    drive_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'd0);
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_stall", {31'd0, stall}, 32'd0);
      check_eq("rst_ready", {31'd0, req_ready}, 32'd0);
    end
    check_eq("rst_dmem_req", {31'd0, bus.dmem_req}, 32'd0);
    check_eq("rst_dmem_addr", bus.dmem_addr, 32'd0);
    check_eq("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check_eq("rst_err_code", {30'd0, err_code}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_inputs();

    // no-op request: neither read nor write
    req_valid = 1'b1;
    @(negedge clk);
    check_eq("noop_stall", {31'd0, stall}, 32'd0);
    check_eq("noop_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    idle_inputs();
    @(posedge clk);
    #1;

    do_op("ldb",  1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_1003, 32'd0, 0, 1'b0, 32'h80FF_1234,
          32'hFFFF_FF80, 1'b0, 2'd0, 3, 1, 32'h0000_1000, 4'b0000, 32'd0);
    do_op("ldbu", 1'b1, 1'b0, 2'd0, 1'b1, 32'h0000_1003, 32'd0, 0, 1'b0, 32'h80FF_1234,
          32'h0000_0080, 1'b0, 2'd0, 3, 1, 32'h0000_1000, 4'b0000, 32'd0);
    do_op("sth",  1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_2002, 32'hAAAA_BEEF, 3, 1'b0, 32'd0,
          32'd0, 1'b0, 2'd0, 5, 4, 32'h0000_2000, 4'b1100, 32'hBEEF_BEEF);
    do_op("ldh",  1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_5002, 32'd0, 0, 1'b0, 32'h8001_7FFF,
          32'hFFFF_8001, 1'b0, 2'd0, 3, 1, 32'h0000_5000, 4'b0000, 32'd0);
    do_op("ldhu", 1'b1, 1'b0, 2'd1, 1'b1, 32'h0000_5000, 32'd0, 0, 1'b0, 32'h1234_F00D,
          32'h0000_F00D, 1'b0, 2'd0, 3, 1, 32'h0000_5000, 4'b0000, 32'd0);
    do_op("ldb1", 1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_5001, 32'd0, 0, 1'b0, 32'h0000_7F00,
          32'h0000_007F, 1'b0, 2'd0, 3, 1, 32'h0000_5000, 4'b0000, 32'd0);
    do_op("stb",  1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_6001, 32'h1234_5678, 0, 1'b0, 32'd0,
          32'd0, 1'b0, 2'd0, 2, 1, 32'h0000_6000, 4'b0010, 32'h7878_7878);
    do_op("stw",  1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_6004, 32'hDEAD_BEEF, 0, 1'b0, 32'd0,
          32'd0, 1'b0, 2'd0, 2, 1, 32'h0000_6004, 4'b1111, 32'hDEAD_BEEF);
    do_op("ldw_mis", 1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_3001, 32'd0, 0, 1'b0, 32'd0,
          32'd0, 1'b1, 2'd1, 1, 0, 32'd0, 4'd0, 32'd0);
    do_op("sth_mis", 1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_3003, 32'h1111_2222, 0, 1'b0, 32'd0,
          32'd0, 1'b1, 2'd1, 1, 0, 32'd0, 4'd0, 32'd0);
    do_op("rdwr_ill", 1'b1, 1'b1, 2'd2, 1'b0, 32'h0000_3000, 32'd0, 0, 1'b0, 32'd0,
          32'd0, 1'b1, 2'd2, 1, 0, 32'd0, 4'd0, 32'd0);
    do_op("sz3_ill", 1'b1, 1'b0, 2'd3, 1'b0, 32'h0000_3001, 32'd0, 0, 1'b0, 32'd0,
          32'd0, 1'b1, 2'd2, 1, 0, 32'd0, 4'd0, 32'd0);
    do_op("tmo_wait", 1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_4000, 32'd0, 0, 1'b1, 32'h5555_5555,
          32'd0, 1'b1, 2'd3, 6, 1, 32'h0000_4000, 4'b0000, 32'd0);
    do_op("tmo_req", 1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_4004, 32'h0BAD_F00D, 255, 1'b0, 32'd0,
          32'd0, 1'b1, 2'd3, 5, 4, 32'h0000_4004, 4'b1111, 32'h0BAD_F00D);
    do_op("gnt_last", 1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_4008, 32'd0, 3, 1'b0, 32'hCAFE_0001,
          32'hCAFE_0001, 1'b0, 2'd0, 6, 4, 32'h0000_4008, 4'b0000, 32'd0);

    // back-to-back word loads with req_valid held high
    gnt_wait = 0;
    rv_never = 1'b0;
    mem_word = 32'h1122_3344;
    drive_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_7000, 32'd0);
    base = resp_count;
    sb_q.push_back('{cyc: cyc + 3, rdata: 32'h1122_3344, err: 1'b0, code: 2'd0});
    sb_q.push_back('{cyc: cyc + 7, rdata: 32'h1122_3344, err: 1'b0, code: 2'd0});
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq("b2b_stall", {31'd0, stall}, {31'd0, ~resp_valid});
    end
    @(posedge clk);
    #1;
    idle_inputs();
    check_eq("b2b_count", resp_count - base, 2);

    // reset while the access sits in REQ
    gnt_wait = 255;
    drive_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_7100, 32'd0);
    @(posedge clk);
    #1;
    idle_inputs();
    @(negedge clk);
    check_eq("midrst_req_before", {31'd0, bus.dmem_req}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_stall", {31'd0, stall}, 32'd0);
    check_eq("midrst_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    base = resp_count;
    @(negedge clk);
    check_eq("midrst_req_after", {31'd0, bus.dmem_req}, 32'd0);
    check_eq("midrst_idle", {31'd0, req_ready}, 32'd1);
    k = 0;
    while (k < 6) begin
      @(negedge clk);
      k++;
    end
    check_eq("midrst_no_resp", resp_count - base, 0);
    check_eq("sb_empty", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
